// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and FSM encoding for the AES block sequencer
package aes_pkg;

    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_NBYTES     = 16;
    localparam int AES_NROUNDS    = 10;

    typedef logic [1:0] aes_state_t;

    localparam aes_state_t LOAD_KEY  = 2'd0;
    localparam aes_state_t LOAD_DATA = 2'd1;
    localparam aes_state_t RUN       = 2'd2;
    localparam aes_state_t DONE      = 2'd3;

endpackage

// File: rtl/aes_block_sequencer_if.sv
// rtl/aes_block_sequencer_if.sv - byte stream, result and core-side bundle of the AES sequencer
interface aes_block_sequencer_if;
    import aes_pkg::*;

    logic [7:0]                s_data;
    logic                      s_valid;
    logic                      s_ready;
    logic [AES_BLOCK_BITS-1:0] m_data;
    logic                      m_valid;
    logic                      m_ready;
    logic [AES_BLOCK_BITS-1:0] core_key;
    logic [AES_BLOCK_BITS-1:0] core_data;
    logic                      core_en;
    logic                      core_clr;
    logic [AES_BLOCK_BITS-1:0] core_out;

    modport master (
        input  s_data, s_valid, m_ready, core_out,
        output s_ready, m_data, m_valid, core_key, core_data, core_en, core_clr
    );

    modport slave (
        output s_data, s_valid, m_ready, core_out,
        input  s_ready, m_data, m_valid, core_key, core_data, core_en, core_clr
    );

endinterface

// File: rtl/aes_byte_packer.sv
// rtl/aes_byte_packer.sv - 8-to-128 shift register with byte count and full pulse
import aes_pkg::*;

module aes_byte_packer #(
    parameter int NBYTES = AES_NBYTES
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [7:0]            data_byte,
    output logic [8*NBYTES-1:0]   word,
    output logic                  full
);

    localparam int CW = $clog2(NBYTES);

    logic [CW-1:0] bcnt;

    // full marks the accept of the last byte; the counter wraps on that edge
    assign full = load && (bcnt == CW'(NBYTES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            word <= '0;
            bcnt <= '0;
        end else if (load) begin
            word <= {word[8*NBYTES-9:0], data_byte};
            bcnt <= full ? '0 : bcnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - loads key and plaintext bytes, runs the iterative AES core, returns ciphertext
import aes_pkg::*;

module aes_block_sequencer #(
    parameter int NBYTES  = AES_NBYTES,
    parameter int NROUNDS = AES_NROUNDS
) (
    input  logic                  clk,
    input  logic                  clr,
    aes_block_sequencer_if.master bus,
    output logic                  busy
);

    localparam int RW = $clog2(NROUNDS);

    aes_state_t    state;
    logic [RW-1:0] rcnt;
    logic          key_full;
    logic          data_full;

    aes_byte_packer #(.NBYTES(NBYTES)) u_key_packer (
        .clk       (clk),
        .clr       (clr),
        .load      (bus.s_valid && (state == LOAD_KEY)),
        .data_byte (bus.s_data),
        .word      (bus.core_key),
        .full      (key_full)
    );

    aes_byte_packer #(.NBYTES(NBYTES)) u_data_packer (
        .clk       (clk),
        .clr       (clr),
        .load      (bus.s_valid && (state == LOAD_DATA)),
        .data_byte (bus.s_data),
        .word      (bus.core_data),
        .full      (data_full)
    );

    // core_clr carries clr directly so a reset reaches the core without waiting for a clock
    assign bus.s_ready  = (state == LOAD_KEY) || (state == LOAD_DATA);
    assign bus.core_en  = (state == RUN);
    assign bus.core_clr = clr || (state != RUN);
    assign busy         = (state == RUN) || (state == DONE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= LOAD_KEY;
            rcnt        <= '0;
            bus.m_data  <= '0;
            bus.m_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_KEY: begin
                    if (key_full) state <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (data_full) begin
                        rcnt  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rcnt <= rcnt + 1'b1;
                    // core round counter tracks rcnt, so its output is the ciphertext here
                    if (rcnt == RW'(NROUNDS - 1)) begin
                        bus.m_data  <= bus.core_out;
                        bus.m_valid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        state       <= LOAD_KEY;
                    end
                end
                default: state <= LOAD_KEY;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - self-checking bench with a behavioural AES-128 core and reference model
module tb_aes_block_sequencer;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           gap;
        int           bp;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes_block_sequencer_if bus();

    aes_block_sequencer dut (
        .clk  (clk),
        .clr  (clr),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[127 - 8*int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state sits at row i%4, column i/4
    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   k[16];
        logic [7:0]   rcon;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rcon = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sbox(s[r + 4*((c + r) % 4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            k[0] = k[0] ^ sbox(k[13]) ^ rcon;
            k[1] = k[1] ^ sbox(k[14]);
            k[2] = k[2] ^ sbox(k[15]);
            k[3] = k[3] ^ sbox(k[12]);
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rcon = xt(rcon);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Iterative core: round counter held at 0 by core_clr; output is the ciphertext only on round 9
    logic [3:0]   core_r;
    logic [127:0] cipher;

    always @(posedge clk) begin
        if (bus.core_clr)     core_r <= 4'd0;
        else if (bus.core_en) core_r <= core_r + 4'd1;
    end

    always_comb begin
        cipher       = aes128(bus.core_key, bus.core_data);
        bus.core_out = (core_r == 4'd9) ? cipher : cipher ^ {32{core_r + 4'd1}};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bytes(input logic [255:0] stream, input int n, input int gap, input string tag);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = stream[255-8*i -: 8];
            if (!bus.s_ready || busy) bad = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        check({tag, " load s_ready"}, 128'(bad), 128'(0));
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int           edges;
        bit           bad;
        logic [127:0] held;
        bus.m_ready = (v.bp == 0);
        send_bytes({v.key, v.pt}, 32, v.gap, tag);
        // a pending byte upstream during RUN/DONE must be ignored
        bus.s_valid = 1'b1;
        bus.s_data  = 8'ha5;
        edges = 0;
        bad   = 1'b0;
        while (!bus.m_valid && edges < 40) begin
            if (bus.s_ready || !busy || !bus.core_en || bus.core_clr) bad = 1'b1;
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, 128'(edges), 128'(AES_NROUNDS));
        check({tag, " ciphertext"}, bus.m_data, v.ct);
        check({tag, " run controls"}, 128'(bad), 128'(0));
        held = bus.m_data;
        bad  = 1'b0;
        for (int i = 0; i < v.bp; i++) begin
            if (!bus.m_valid || bus.m_data !== held || !bus.core_clr || bus.core_en
                || bus.s_ready || !busy) bad = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        if (v.bp > 0) check({tag, " backpressure hold"}, 128'(bad), 128'(0));
        @(negedge clk);
        check({tag, " m_valid clears"}, 128'(bus.m_valid), 128'(0));
        check({tag, " back to load"}, {126'(0), bus.s_ready, busy}, 128'b10);
        check({tag, " m_data kept"}, bus.m_data, held);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m_valid"}, 128'(bus.m_valid), 128'(0));
        check({tag, " m_data"}, bus.m_data, 128'(0));
        check({tag, " ctl s_ready/core_clr/core_en/busy"},
              {124'(0), bus.s_ready, bus.core_clr, bus.core_en, busy}, 128'b1100);
    endtask

    vec_t vecs[9];

    initial begin
        int  edges;
        bit  bad;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;

        vecs[0] = '{C1_KEY, C1_PT, C1_CT, 0, 0};
        vecs[1] = '{C1_KEY, C1_PT, C1_CT, 50, 0};
        vecs[2] = '{C1_KEY, C1_PT, C1_CT, 0, 20};
        vecs[3] = '{B_KEY, B_PT, B_CT, 0, 0};
        vecs[4] = '{C1_KEY, C1_PT, C1_CT, 0, 0};
        for (int i = 5; i < 9; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = aes128(vecs[i].key, vecs[i].pt);
            vecs[i].gap = int'($urandom_range(60));
            vecs[i].bp  = int'($urandom_range(5));
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        // abort while the core is mid-run
        bus.m_ready = 1'b1;
        send_bytes({C1_KEY, C1_PT}, 32, 0, "abort run");
        repeat (5) @(negedge clk);
        clr = 1'b1;
        #1;
        check_reset_outputs("clr in run");
        @(negedge clk);
        clr = 1'b0;
        bad = 1'b0;
        for (edges = 0; edges < 15; edges++) begin
            if (bus.m_valid) bad = 1'b1;
            @(negedge clk);
        end
        check("aborted block silent", 128'(bad), 128'(0));
        run_block(vecs[0], "after run abort");

        // abort partway through the key
        send_bytes({vecs[5].key, vecs[5].pt}, 7, 0, "abort load");
        clr = 1'b1;
        #1;
        check_reset_outputs("clr in load");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        run_block(vecs[6], "after load abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
Upstream front end for the iterative AES-128 encryption core. It accepts a byte stream on a valid/ready handshake and assembles a 128-bit key, then a 128-bit plaintext block. It holds them stable on the core inputs and drives the core's clr/en through exactly 10 round cycles. It captures the ciphertext on the final round cycle and presents it on a 128-bit valid/ready result port.

Parameters:
NBYTES, 16, bytes per key and per data block (fixed for AES-128; counter width $clog2(NBYTES))
NROUNDS, 10, core round cycles from core release to ciphertext-valid

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-high
s_data  input  8  input byte; 16 key bytes then 16 plaintext bytes, first byte -> bits [127:120]
s_valid  input  1  s_data valid
s_ready  output  1  block accepts byte this cycle
m_data  output  128  captured ciphertext
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts m_data
core_key  output  128  key to core, stable from RUN entry until DONE exit
core_data  output  128  plaintext to core, same stability
core_en  output  1  core register enable
core_clr  output  1  core clear; holds core round counter at 0
core_out  input  128  core data_out
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, clr).
- States: LOAD_KEY, LOAD_DATA, RUN, DONE.
- Reset values: state=LOAD_KEY, bcnt=0, rcnt=0, key/data/m_data registers=0, m_valid=0, s_ready=1, core_en=0, core_clr=1, busy=0.
- Byte accept: when s_valid and s_ready are both high, shift the shift register left 8 and place s_data in [7:0]; bcnt increments.
- LOAD_KEY:
  - s_ready=1; bytes go to the key register.
  - When bcnt==15 and a byte is accepted: bcnt wraps to 0 and state goes to LOAD_DATA.
- LOAD_DATA:
  - s_ready=1; bytes go to the data register.
  - When bcnt==15 and a byte is accepted: bcnt wraps to 0, rcnt=0, state goes to RUN.
- RUN:
  - s_ready=0, core_clr=0, core_en=1; rcnt increments each cycle.
  - The core round counter equals rcnt by construction, since both leave clear on the same edge.
  - On the edge where rcnt==NROUNDS-1: m_data<=core_out, m_valid<=1, state goes to DONE.
- DONE:
  - s_ready=0, core_clr=1, core_en=0.
  - m_data and m_valid are held until m_ready is high.
  - On that edge: m_valid<=0, state goes to LOAD_KEY.
  - m_data keeps its last value.
- core_clr = clr OR (state != RUN), combinational, so reset reaches the core asynchronously.
- Latency: m_valid rises exactly NROUNDS (10) rising edges after the edge that accepts the last plaintext byte.
- Throughput: one block per 32 + 10 + 1 cycles minimum.
- s_valid gaps: byte stalls in either load state are legal; bcnt and the partial registers hold.
- Backpressure: m_ready low in DONE holds indefinitely; no input is accepted meanwhile.
- s_valid high in RUN/DONE: ignored; the byte stays pending upstream.
- m_ready high outside DONE: ignored.
- Reset mid-operation: clr asserted in any state returns all outputs to reset values immediately. A partially loaded key or data block is discarded; a pending m_valid is dropped.
- No output is combinationally dependent on s_valid or m_ready. s_ready, core_en, core_clr (apart from the clr term) and busy decode from state only.

Decomposition:
- Shared package aes_pkg:
  - state enum (LOAD_KEY, LOAD_DATA, RUN, DONE)
  - constants AES_BLOCK_BITS=128, AES_NBYTES=16, AES_NROUNDS=10
- One natural sub-module: aes_byte_packer.
  - Function: 8-to-128 shift register with bcnt and a 'full' pulse on the 16th accepted byte.
  - Instances: two, one for the key and one for the data. Alternatively one instance time-shared by state.
- The FSM and rcnt stay in the top.

Test Plan:
- FIPS-197 C.1, contiguous:
  - Stimulus: key bytes 00..0f, plaintext 00 11 22 .. ff, core attached, m_ready=1.
  - Required: m_data=69c4e0d86a7b0430d8cdb78070b4c55a; m_valid high exactly 10 edges after the last byte edge, for one cycle; block then returns to LOAD_KEY.
- Gapped input:
  - Stimulus: same vectors with s_valid toggled randomly (about 50%).
  - Required: identical m_data; bcnt holds during gaps; s_ready low throughout RUN/DONE.
- Backpressure:
  - Stimulus: m_ready=0 for 20 cycles after m_valid rises, then 1.
  - Required: m_data stable; core_clr=1 and s_ready=0 during the hold; m_valid clears on the m_ready edge.
- FIPS-197 B, back-to-back:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, then C.1 vectors immediately after.
  - Required: outputs 3925841d02dc09fbdc118597196a0b32, then 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset in RUN:
  - Stimulus: assert clr at rcnt=5 for 1 cycle, then reload the C.1 vectors.
  - Required: immediately on clr, m_valid=0, core_clr=1, state=LOAD_KEY; no output from the aborted block; the next result is correct.
- Reset in load:
  - Stimulus: clr after 7 key bytes.
  - Required: bcnt=0; the following 32-byte stream produces the correct ciphertext.
